// File: rtl/alu_memory.sv
// 32-bit MIPS-style ALU feeding a 32-word scratch memory written on clk, read combinationally.
// Optional macro ALU_MEMORY_BYPASS_EN forwards the ALU result to Mout whenever Ewr is high.
module alu_memory #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Ewr,
  input  logic [ADDR_W-1:0] Dir,
  input  logic [2:0]        Sel,
  input  logic [DATA_W-1:0] Op1,
  input  logic [DATA_W-1:0] Op2,
  output logic [DATA_W-1:0] Mout,
  output logic              Zeroflag
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_NOR = 3'b100,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  logic [DATA_W-1:0] alu_r;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    alu_r = '0;
    case (alu_op_e'(Sel))
      OP_AND:  alu_r = Op1 & Op2;
      OP_OR:   alu_r = Op1 | Op2;
      OP_ADD:  alu_r = Op1 + Op2;
      OP_NOR:  alu_r = ~(Op1 | Op2);
      OP_SUB:  alu_r = Op1 - Op2;
      OP_SLT:  alu_r = ($signed(Op1) < $signed(Op2)) ? DATA_W'(1) : '0;
      default: alu_r = '0;
    endcase
  end

  assign Zeroflag = (alu_r == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (Ewr) begin
      mem_q[Dir] <= alu_r;
    end
  end

  assign rd_word = mem_q[Dir];

`ifdef ALU_MEMORY_BYPASS_EN
  assign Mout = Ewr ? alu_r : rd_word;
`else
  assign Mout = rd_word;
`endif

endmodule

// File: tb/tb_alu_memory.sv
// Directed self-checking bench for alu_memory: reset, ALU ops, write/read, write protection.
module tb_alu_memory;

  logic        clk;
  logic        rst;
  logic        Ewr;
  logic [4:0]  Dir;
  logic [2:0]  Sel;
  logic [31:0] Op1;
  logic [31:0] Op2;
  logic [31:0] Mout;
  logic        Zeroflag;

  int n_tests = 0;
  int n_fail  = 0;

  alu_memory #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .Ewr      (Ewr),
    .Dir      (Dir),
    .Sel      (Sel),
    .Op1      (Op1),
    .Op2      (Op2),
    .Mout     (Mout),
    .Zeroflag (Zeroflag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive an op with Ewr=1 between edges, check the flag, then check the stored word after the edge.
  task automatic do_write(input string tag, input logic [2:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] dir,
                          input logic exp_zero, input logic [31:0] exp_word);
    @(negedge clk);
    Sel = sel; Op1 = a; Op2 = b; Dir = dir; Ewr = 1'b1;
    #1;
    check({tag, "_zf"}, {31'd0, Zeroflag}, {31'd0, exp_zero});
    @(posedge clk);
    #1;
    Ewr = 1'b0;
    #1;
    check({tag, "_mout"}, Mout, exp_word);
  endtask

  task automatic read_at(input string tag, input logic [4:0] dir, input logic [31:0] exp_word);
    Dir = dir;
    #1;
    check(tag, Mout, exp_word);
  endtask

  initial begin
    rst = 1'b0; Ewr = 1'b0; Dir = '0; Sel = '0; Op1 = '0; Op2 = '0;
    #1;
    rst = 1'b1;
    #2;
    for (int i = 0; i < 32; i++) begin
      read_at("reset_clear", 5'(i), 32'd0);
    end
    rst = 1'b0;

    // Read-during-write: old word visible before the edge in the default build.
    @(negedge clk);
    Sel = 3'b111; Op1 = 32'd1050; Op2 = 32'd1150; Dir = 5'd1; Ewr = 1'b1;
    #1;
`ifdef ALU_MEMORY_BYPASS_EN
    check("rdw_pre_edge", Mout, 32'd1);
`else
    check("rdw_pre_edge", Mout, 32'd0);
`endif
    Ewr = 1'b0;

    do_write("slt_wr",   3'b111, 32'd1050, 32'd1150, 5'd1,  1'b0, 32'd1);
    do_write("sub_wr",   3'b110, 32'd1050, 32'd1150, 5'd15, 1'b0, 32'hFFFFFF9C);
    do_write("nor_wr",   3'b100, 32'd1050, 32'd1150, 5'd31, 1'b0, 32'hFFFFFB81);
    read_at("hold_dir1",  5'd1,  32'd1);
    read_at("hold_dir15", 5'd15, 32'hFFFFFF9C);

    do_write("and_wr",   3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd2, 1'b0, 32'h00F000F0);
    do_write("add_wrap", 3'b010, 32'hFFFFFFFF, 32'd1,        5'd2, 1'b1, 32'd0);
    do_write("or_wr",    3'b001, 32'h00001200, 32'h00000034, 5'd3, 1'b0, 32'h00001234);
    do_write("add_wr",   3'b010, 32'd7,        32'd8,        5'd4, 1'b0, 32'd15);
    do_write("sub_zero", 3'b110, 32'd5,        32'd5,        5'd8, 1'b1, 32'd0);
    do_write("slt_neg",  3'b111, 32'hFFFFFFFF, 32'd1,        5'd5, 1'b0, 32'd1);
    do_write("slt_pos",  3'b111, 32'd1,        32'hFFFFFFFF, 5'd6, 1'b1, 32'd0);
    do_write("pre7",     3'b010, 32'd7,        32'd8,        5'd7, 1'b0, 32'd15);
    do_write("unused011",3'b011, 32'd3,        32'd4,        5'd7, 1'b1, 32'd0);
    do_write("pre9",     3'b001, 32'd9,        32'd0,        5'd9, 1'b0, 32'd9);
    do_write("unused101",3'b101, 32'd3,        32'd4,        5'd9, 1'b1, 32'd0);

    // New results with Ewr=0 must not disturb the stored word.
    @(negedge clk);
    Sel = 3'b010; Op1 = 32'd100; Op2 = 32'd200; Dir = 5'd1; Ewr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("ewr0_hold", Mout, 32'd1);
    end

    // Asynchronous reset between edges, then writes ignored while held.
    @(negedge clk);
    rst = 1'b1;
    #1;
    read_at("mid_rst_dir1",  5'd1,  32'd0);
    read_at("mid_rst_dir15", 5'd15, 32'd0);
    read_at("mid_rst_dir31", 5'd31, 32'd0);
    Dir = 5'd1; Sel = 3'b010; Op1 = 32'd100; Op2 = 32'd200;
    Ewr = 1'b1;
    @(posedge clk);
    #1;
    Ewr = 1'b0;
    #1;
    check("rst_blocks_wr", Mout, 32'd0);
    check("zf_in_rst", {31'd0, Zeroflag}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_write("post_rst_wr", 3'b010, 32'd100, 32'd200, 5'd1, 1'b0, 32'd300);
    read_at("post_rst_dir4", 5'd4, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
